// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- types and constants shared by the hazard unit.
//   fwd_sel_t   : Execute-stage operand source (register file, Writeback, Memory)
//   hz_state_t  : data-memory wait FSM states
//   RESULT_LOAD : ResultSrcE encoding that marks a load in Execute
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN  = 2'b00,
        HZ_WAIT = 2'b01,
        HZ_ERR  = 2'b10
    } hz_state_t;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle of every pipeline-facing signal of the hazard unit.
//   master : pipeline side; drives register numbers, write-enable codes,
//            redirect and memory handshake, receives forward/stall/flush.
//   slave  : hazard-unit side (mirror of master).
//   CNT_WIDTH sizes the performance counter fields.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]           result_src_e;
    logic [2:0]           reg_write_m, reg_write_w;
    logic [1:0]           pc_src_e;
    logic                 mem_req_m, mem_ready_m;
    logic [1:0]           forward_ae, forward_be;
    logic                 stall_f, stall_d, stall_e, stall_m;
    logic                 flush_d, flush_e, flush_w;
    logic                 mem_err;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output result_src_e, reg_write_m, reg_write_w, pc_src_e,
        output mem_req_m, mem_ready_m,
        input  forward_ae, forward_be,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  result_src_e, reg_write_m, reg_write_w, pc_src_e,
        input  mem_req_m, mem_ready_m,
        output forward_ae, forward_be,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/forward_sel.sv
// forward_sel -- operand forwarding select for one Execute-stage source.
//   rs_e_i                  : source register number in Execute
//   rd_m_i / reg_write_m_i  : Memory-stage destination and write-enable code
//   rd_w_i / reg_write_w_i  : Writeback-stage destination and write-enable code
//   sel_o                   : FWD_M, FWD_W or FWD_REG (purely combinational)
module forward_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic [2:0] reg_write_m_i,
    input  logic [2:0] reg_write_w_i,
    output fwd_sel_t   sel_o
);
    // Memory stage holds the younger result, so it wins over Writeback.
    // x0 is hard-wired zero and is never forwarded.
    always_comb begin
        sel_o = FWD_REG;
        if (rs_e_i != 5'd0 && rs_e_i == rd_m_i && reg_write_m_i != 3'd0) begin
            sel_o = FWD_M;
        end else if (rs_e_i != 5'd0 && rs_e_i == rd_w_i && reg_write_w_i != 3'd0) begin
            sel_o = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit: forwarding, load-use stall, branch
// flush, data-memory wait/timeout handling and stall/flush counters.
//   clk, rst               : clock, synchronous active-high reset
//   Rs*/Rd* inputs         : register numbers of Decode/Execute/Memory/Writeback
//   ResultSrcE_i           : RESULT_LOAD marks a load in Execute
//   RegWriteM_i/W_i        : nonzero when that stage writes its rd
//   PCSrcE_i               : nonzero for a taken branch/jump in Execute
//   MemReqM_i/MemReadyM_i  : data-memory request / completion handshake
//   ForwardAE_o/BE_o       : operand mux selects
//   Stall*_o / Flush*_o    : pipeline register hold / bubble controls
//   MemErr_o               : sticky data-memory timeout
//   StallCnt_o/FlushCnt_o  : saturating counts of StallF and FlushE cycles
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D_i,
    input  logic [4:0]           Rs2D_i,
    input  logic [4:0]           Rs1E_i,
    input  logic [4:0]           Rs2E_i,
    input  logic [4:0]           RdE_i,
    input  logic [4:0]           RdM_i,
    input  logic [4:0]           RdW_i,
    input  logic [1:0]           ResultSrcE_i,
    input  logic [2:0]           RegWriteM_i,
    input  logic [2:0]           RegWriteW_i,
    input  logic [1:0]           PCSrcE_i,
    input  logic                 MemReqM_i,
    input  logic                 MemReadyM_i,
    output logic [1:0]           ForwardAE_o,
    output logic [1:0]           ForwardBE_o,
    output logic                 StallF_o,
    output logic                 StallD_o,
    output logic                 StallE_o,
    output logic                 StallM_o,
    output logic                 FlushD_o,
    output logic                 FlushE_o,
    output logic                 FlushW_o,
    output logic                 MemErr_o,
    output logic [CNT_WIDTH-1:0] StallCnt_o,
    output logic [CNT_WIDTH-1:0] FlushCnt_o
);
    localparam int              WW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    hz_state_t            state_q, state_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 lw_stall, mem_stall, redirect;

    // ---------------- forwarding: one selector per Execute source ----------
    logic [4:0] rs_e [2];
    fwd_sel_t   fwd  [2];

    assign rs_e[0] = Rs1E_i;
    assign rs_e[1] = Rs2E_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            forward_sel u_fwd (
                .rs_e_i        (rs_e[gi]),
                .rd_m_i        (RdM_i),
                .rd_w_i        (RdW_i),
                .reg_write_m_i (RegWriteM_i),
                .reg_write_w_i (RegWriteW_i),
                .sel_o         (fwd[gi])
            );
        end
    endgenerate

    assign ForwardAE_o = fwd[0];
    assign ForwardBE_o = fwd[1];

    // ---------------- load-use and redirect detection -----------------------
    assign lw_stall = (ResultSrcE_i == RESULT_LOAD) && (RdE_i != 5'd0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign redirect = (PCSrcE_i != 2'd0);

    // ---------------- data-memory wait FSM ----------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (MemReqM_i && !MemReadyM_i) begin
                    state_d    = HZ_WAIT;
                    wait_cnt_d = '0;
                    mem_stall  = 1'b1;
                end
            end
            HZ_WAIT: begin
                mem_stall = !MemReadyM_i;
                // Ready is checked first so a late completion on the
                // timeout cycle still returns to RUN.
                if (MemReadyM_i) begin
                    state_d = HZ_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = HZ_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            HZ_ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    // ---------------- stall / flush outputs ---------------------------------
    // A memory stall freezes F..M and bubbles W; a pending redirect is held
    // in Execute by StallE and takes effect on the cycle memory completes.
    always_comb begin
        StallF_o = lw_stall;
        StallD_o = lw_stall;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        FlushD_o = redirect;
        FlushE_o = lw_stall || redirect;
        FlushW_o = 1'b0;
        if (mem_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushD_o = 1'b0;
            FlushE_o = 1'b0;
            FlushW_o = 1'b1;
        end
    end

    // ---------------- saturating performance counters -----------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushE_o && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemErr_o   = (state_q == HZ_ERR);
    assign StallCnt_o = stall_cnt_q;
    assign FlushCnt_o = flush_cnt_q;

endmodule
